// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch controller: IDLE/RUN/PAUSE FSM, prescaled tick,
// ripple-carry BCD count with sticky overflow, and a toggling lap freeze.
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        ovf,
  output logic        lap_valid
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  state_t      state, state_nx;
  logic [15:0] presc, presc_nx;
  logic [15:0] count, count_nx;
  logic [15:0] lap_reg, lap_nx;
  logic        ovf_nx, lap_valid_nx;
  logic        tick, carry;

  // Returns {carry_out, incremented value}; carry_out is set only on 9999 -> 0000.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nx     = state;
    presc_nx     = presc;
    count_nx     = count;
    lap_nx       = lap_reg;
    ovf_nx       = ovf;
    lap_valid_nx = lap_valid;
    carry        = 1'b0;
    tick         = (state == RUN) && (presc == PRESC_LAST);

    if (state == RUN) begin
      presc_nx = tick ? 16'd0 : presc + 16'd1;
    end
    if (tick) begin
      {carry, count_nx} = bcd_inc(count);
      if (carry) ovf_nx = 1'b1;
    end

    if (clear) begin
      state_nx = IDLE;
    end else if (stop && state == RUN) begin
      state_nx = PAUSE;
    end else if (start && state != RUN) begin
      state_nx = RUN;
    end

    // The lap snapshot includes any increment landing on the same edge.
    if (lap) begin
      if (lap_valid) begin
        lap_valid_nx = 1'b0;
      end else if (state == RUN) begin
        lap_nx       = count_nx;
        lap_valid_nx = 1'b1;
      end
    end

    if (clear) begin
      presc_nx     = 16'd0;
      count_nx     = 16'd0;
      lap_nx       = 16'd0;
      ovf_nx       = 1'b0;
      lap_valid_nx = 1'b0;
    end
  end

  // Outputs are registered from the next-state values so they track the state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= 16'd0;
      count     <= 16'd0;
      lap_reg   <= 16'd0;
      ovf       <= 1'b0;
      lap_valid <= 1'b0;
      digits    <= 16'd0;
      running   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state     <= state_nx;
      presc     <= presc_nx;
      count     <= count_nx;
      lap_reg   <= lap_nx;
      ovf       <= ovf_nx;
      lap_valid <= lap_valid_nx;
      digits    <= lap_valid_nx ? lap_nx : count_nx;
      running   <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl at TICK_DIV=4; inputs change and
// outputs are sampled on the falling edge.
module tb_bcd_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] digits;
  logic        running, ovf, lap_valid;

  int checks = 0;
  int errors = 0;

  bcd_stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .lap       (lap),
    .digits    (digits),
    .running   (running),
    .ovf       (ovf),
    .lap_valid (lap_valid)
  );

  always #5 clk = ~clk;

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a one-cycle pulse; returns at the falling edge after the sampling edge.
  task automatic pulse(input logic s_start, input logic s_stop,
                       input logic s_clear, input logic s_lap);
    start = s_start; stop = s_stop; clear = s_clear; lap = s_lap;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0 || lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits=%h running=%b ovf=%b lap_valid=%b expected 0000/0/0/0",
               digits, running, ovf, lap_valid);
    end
    reset = 1'b1;
    wait_edges(2);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: digits=%h running=%b expected 0000/0", digits, running);
    end
  endtask

  task automatic test_start_count;
    pulse(1, 0, 0, 0);
    checks++;
    if (running !== 1'b1 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL start_running: running=%b digits=%h expected 1/0000", running, digits);
    end
    wait_edges(3);
    checks++;
    if (digits !== 16'h0000) begin
      errors++;
      $display("FAIL before_first_tick: digits=%h expected 0000", digits);
    end
    wait_edges(1);
    checks++;
    if (digits !== 16'h0001) begin
      errors++;
      $display("FAIL first_tick: digits=%h expected 0001", digits);
    end
    wait_edges(36);
    checks++;
    if (digits !== 16'h0010) begin
      errors++;
      $display("FAIL tens_carry: digits=%h expected 0010", digits);
    end
  endtask

  task automatic test_pause_resume;
    pulse(0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: digits=%h running=%b expected 0000/0", digits, running);
    end
    pulse(1, 0, 0, 0);
    wait_edges(20);
    checks++;
    if (digits !== 16'h0005) begin
      errors++;
      $display("FAIL run_to_5: digits=%h expected 0005", digits);
    end
    pulse(0, 1, 0, 0);
    checks++;
    if (running !== 1'b0 || digits !== 16'h0005) begin
      errors++;
      $display("FAIL stop_pause: running=%b digits=%h expected 0/0005", running, digits);
    end
    pulse(0, 0, 0, 1);
    checks++;
    if (lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL lap_in_pause: lap_valid=%b expected 0", lap_valid);
    end
    wait_edges(20);
    checks++;
    if (digits !== 16'h0005 || running !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold: digits=%h running=%b expected 0005/0", digits, running);
    end
    pulse(1, 0, 0, 0);
    checks++;
    if (running !== 1'b1 || digits !== 16'h0005) begin
      errors++;
      $display("FAIL resume: running=%b digits=%h expected 1/0005", running, digits);
    end
    wait_edges(2);
    checks++;
    if (digits !== 16'h0005) begin
      errors++;
      $display("FAIL resume_presc_hold: digits=%h expected 0005", digits);
    end
    wait_edges(1);
    checks++;
    if (digits !== 16'h0006) begin
      errors++;
      $display("FAIL resume_tick: digits=%h expected 0006", digits);
    end
  endtask

  task automatic test_lap;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    wait_edges(48);
    checks++;
    if (digits !== 16'h0012) begin
      errors++;
      $display("FAIL run_to_12: digits=%h expected 0012", digits);
    end
    pulse(0, 0, 0, 1);
    checks++;
    if (lap_valid !== 1'b1 || digits !== 16'h0012) begin
      errors++;
      $display("FAIL lap_capture: lap_valid=%b digits=%h expected 1/0012", lap_valid, digits);
    end
    for (int i = 0; i < 12; i++) begin
      wait_edges(1);
      checks++;
      if (digits !== 16'h0012 || lap_valid !== 1'b1 || running !== 1'b1) begin
        errors++;
        $display("FAIL lap_frozen[%0d]: digits=%h lap_valid=%b running=%b expected 0012/1/1",
                 i, digits, lap_valid, running);
      end
    end
    pulse(0, 0, 0, 1);
    checks++;
    if (lap_valid !== 1'b0 || digits !== 16'h0015) begin
      errors++;
      $display("FAIL lap_release: lap_valid=%b digits=%h expected 0/0015", lap_valid, digits);
    end
  endtask

  task automatic test_simultaneous;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    wait_edges(5);
    pulse(1, 0, 1, 0);
    checks++;
    if (running !== 1'b0 || digits !== 16'h0000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_plus_start: running=%b digits=%h ovf=%b expected 0/0000/0",
               running, digits, ovf);
    end
    pulse(1, 0, 0, 0);
    wait_edges(6);
    pulse(1, 1, 0, 0);
    checks++;
    if (running !== 1'b0 || digits !== 16'h0001) begin
      errors++;
      $display("FAIL stop_plus_start: running=%b digits=%h expected 0/0001", running, digits);
    end
    wait_edges(5);
    checks++;
    if (running !== 1'b0 || digits !== 16'h0001) begin
      errors++;
      $display("FAIL stop_plus_start_hold: running=%b digits=%h expected 0/0001", running, digits);
    end
    // Prescaler is held at 3, so a stop on the first RUN edge coincides with a tick.
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    checks++;
    if (running !== 1'b0 || digits !== 16'h0002) begin
      errors++;
      $display("FAIL stop_on_tick: running=%b digits=%h expected 0/0002", running, digits);
    end
  endtask

  task automatic test_overflow;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    wait_edges(39996);
    checks++;
    if (digits !== 16'h9999 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reach_9999: digits=%h ovf=%b expected 9999/0", digits, ovf);
    end
    wait_edges(3);
    checks++;
    if (digits !== 16'h9999) begin
      errors++;
      $display("FAIL before_wrap: digits=%h expected 9999", digits);
    end
    wait_edges(1);
    checks++;
    if (digits !== 16'h0000 || ovf !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap: digits=%h ovf=%b running=%b expected 0000/1/1", digits, ovf, running);
    end
    wait_edges(8);
    checks++;
    if (digits !== 16'h0002 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: digits=%h ovf=%b expected 0002/1", digits, ovf);
    end
    pulse(0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0000 || ovf !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: digits=%h ovf=%b running=%b expected 0000/0/0", digits, ovf, running);
    end
  endtask

  task automatic test_async_reset;
    pulse(1, 0, 0, 0);
    wait_edges(10);
    pulse(0, 0, 0, 1);
    checks++;
    if (digits !== 16'h0002 || lap_valid !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: digits=%h lap_valid=%b running=%b expected 0002/1/1",
               digits, lap_valid, running);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0 || lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: digits=%h running=%b ovf=%b lap_valid=%b expected 0000/0/0/0",
               digits, running, ovf, lap_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_edges(10);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL stay_idle_after_reset: digits=%h running=%b expected 0000/0", digits, running);
    end
    pulse(1, 0, 0, 0);
    wait_edges(4);
    checks++;
    if (running !== 1'b1 || digits !== 16'h0001) begin
      errors++;
      $display("FAIL restart_after_reset: running=%b digits=%h expected 1/0001", running, digits);
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_pause_resume();
    test_lap();
    test_simultaneous();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10: clk cycles per count increment; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse; start or resume counting.
REQ-005 SHALL have port stop, input, 1 bit: one-cycle pulse; pause counting.
REQ-006 SHALL have port clear, input, 1 bit: one-cycle pulse; return to zero and idle.
REQ-007 SHALL have port lap, input, 1 bit: one-cycle pulse; toggle display freeze.
REQ-008 SHALL have port digits, output, 16 bits: four BCD digits, [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-009 SHALL have port running, output, 1 bit: high only in state RUN.
REQ-010 SHALL have port ovf, output, 1 bit: sticky flag set on 9999 -> 0000 wrap.
REQ-011 SHALL have port lap_valid, output, 1 bit: high while digits shows a frozen lap value.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and PAUSE; inputs are sampled on the rising edge.
REQ-013 SHALL transition IDLE -> RUN on start, RUN -> PAUSE on stop, PAUSE -> RUN on start, and ANY -> IDLE on clear.
REQ-014 SHALL apply input priority clear > stop > start when pulses coincide; start in RUN and stop in IDLE/PAUSE are no-ops.
REQ-015 SHALL keep a prescaler 0..TICK_DIV-1 that advances on each edge where the pre-edge state is RUN and holds its value in PAUSE.
REQ-016 SHALL increment the internal count on the edge where the prescaler equals TICK_DIV-1 in RUN, wrapping the prescaler to 0 on the same edge.
REQ-017 SHALL therefore make the first increment appear TICK_DIV edges after the edge that enters RUN, with a prescaler of 0 on entry from IDLE.
REQ-018 SHALL ripple-carry the count: a digit at 9 wraps to 0 and increments the next digit in the same edge; no digit ever holds a value above 9.
REQ-019 SHALL wrap 9999 -> 0000, set ovf on that edge, and remain in RUN; ovf stays high until clear or reset.
REQ-020 SHALL drive digits from the internal count when lap_valid=0, and from a lap register when lap_valid=1.
REQ-021 SHALL, on lap in RUN with lap_valid=0, capture the post-edge count into the lap register and set lap_valid while the internal count continues.
REQ-022 SHALL, on lap with lap_valid=1 (any state), clear lap_valid; lap with lap_valid=0 in IDLE or PAUSE is ignored.
REQ-023 SHALL, on clear, zero the count, prescaler, lap register, ovf and lap_valid on the same edge, overriding any coincident tick or lap.
REQ-024 SHALL, on stop coincident with a tick in RUN, apply the increment and then enter PAUSE.
REQ-025 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, while reset=0, force state IDLE and digits=16'h0000, running=0, ovf=0, lap_valid=0, prescaler=0 and lap register=0, independent of clk.
REQ-027 SHALL, when reset asserts mid-RUN, clear immediately and resume only on a start after reset deasserts.

Verification
REQ-028 SHALL be checked with TICK_DIV=4: start pulse -> running=1 next edge; digits=0001 4 edges later; 0010 after 40 edges in RUN.
REQ-029 SHALL be checked with TICK_DIV=4: run to 0005, stop, idle 20 cycles, start -> digits holds 0005 in PAUSE; the prescaler resumes from its held value and 0006 follows at most 4 edges into RUN.
REQ-030 SHALL be checked with TICK_DIV=4: run to 0012, lap -> lap_valid=1 with digits frozen at 0012 for 12 edges; second lap -> digits=0015.
REQ-031 SHALL be checked with TICK_DIV=4 at count 9999: next tick -> digits=0000, ovf=1, running=1; ovf persists until clear, which gives digits=0000 and ovf=0.
REQ-032 SHALL be checked with simultaneous pulses: clear+start in RUN -> IDLE with zeros; stop+start in RUN -> PAUSE.
REQ-033 SHALL be checked with reset asserted asynchronously mid-RUN between edges: outputs are zero before the next clk edge.
